// File: rtl/synth_pkg.sv
// synth_pkg: shared envelope state type and voice constants for the synthesizer
package synth_pkg;
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} env_state_t;
  localparam int N_VOICES = 8;
  localparam logic [31:0] DEFAULT_MAX_LEVEL = 32'h0001_0000;
endpackage

// File: rtl/envelope_step.sv
// envelope_step: one ADSR update for a single voice, gate events taking priority
import synth_pkg::*;
module envelope_step #(
  parameter logic [31:0] MAX_LEVEL = DEFAULT_MAX_LEVEL
) (
  input  env_state_t  state,
  input  logic [31:0] level,
  input  logic [31:0] attack_rate,
  input  logic [31:0] decay_rate,
  input  logic [31:0] release_rate,
  input  logic [31:0] sustain,
  input  logic        on_pend,
  input  logic        off_pend,
  input  logic        gate,
  output env_state_t  next_state,
  output logic [31:0] next_level
);
  logic [32:0] a_sum, d_lim;
  logic        a_hit, d_hit, r_hit;
  logic [31:0] a_lvl, d_lvl, r_lvl, norm_level;
  env_state_t  norm_state;
  assign a_sum = {1'b0, level} + {1'b0, attack_rate};
  assign a_hit = a_sum >= {1'b0, MAX_LEVEL};
  assign a_lvl = a_hit ? MAX_LEVEL : a_sum[31:0];
  assign d_lim = {1'b0, sustain} + {1'b0, decay_rate};
  assign d_hit = {1'b0, level} <= d_lim;
  assign d_lvl = d_hit ? sustain : level - decay_rate;
  assign r_hit = level <= release_rate;
  assign r_lvl = r_hit ? 32'd0 : level - release_rate;
  assign norm_state = state == ATTACK  ? (a_hit ? DECAY : ATTACK) :
                      state == DECAY   ? (d_hit ? SUSTAIN : DECAY) :
                      state == RELEASE ? (r_hit ? IDLE : RELEASE) : state;
  assign norm_level = state == ATTACK  ? a_lvl :
                      state == DECAY   ? d_lvl :
                      state == SUSTAIN ? sustain :
                      state == RELEASE ? r_lvl : 32'd0;
  // Pending key-on beats key-off, which beats the normal per-state step
  always_comb begin
    next_state = norm_state;
    next_level = norm_level;
    if (on_pend) begin
      next_level = a_lvl;
      next_state = !gate ? RELEASE : a_hit ? DECAY : ATTACK;
    end else if (off_pend && state != IDLE) begin
      next_level = r_lvl;
      next_state = r_hit ? IDLE : RELEASE;
    end
  end
endmodule

// File: rtl/envelope_generator.sv
// envelope_generator: eight ADSR envelopes sharing one round-robin update datapath
import synth_pkg::*;
module envelope_generator #(
  parameter int          PRESCALE  = 1024,
  parameter logic [31:0] MAX_LEVEL = DEFAULT_MAX_LEVEL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  gate,
  input  logic [31:0] attack_rate,
  input  logic [31:0] decay_rate,
  input  logic [31:0] sustain_level,
  input  logic [31:0] release_rate,
  output logic [31:0] voice_volumes [N_VOICES-1:0],
  output logic [7:0]  active,
  output logic        sweep_done
);
  localparam int TW = $clog2(PRESCALE);
  logic [TW-1:0] tick_cnt;
  logic [7:0]    gate_q, on_pend, off_pend, clr;
  logic          slot;
  logic [2:0]    v;
  logic [31:0]   s_clamp, nxt_level;
  env_state_t    state [N_VOICES];
  env_state_t    nxt_state;
  assign slot    = tick_cnt < TW'(N_VOICES);
  assign v       = tick_cnt[2:0];
  assign clr     = slot ? 8'd1 << v : 8'd0;
  assign s_clamp = sustain_level > MAX_LEVEL ? MAX_LEVEL : sustain_level;
  for (genvar g = 0; g < N_VOICES; g++) begin : g_act
    assign active[g] = state[g] != IDLE;
  end
  envelope_step #(.MAX_LEVEL(MAX_LEVEL)) u_step (
    .state(state[v]),
    .level(voice_volumes[v]),
    .attack_rate(attack_rate),
    .decay_rate(decay_rate),
    .release_rate(release_rate),
    .sustain(s_clamp),
    .on_pend(on_pend[v]),
    .off_pend(off_pend[v]),
    .gate(gate[v]),
    .next_state(nxt_state),
    .next_level(nxt_level)
  );
  // Prescaler, gate edge capture (set beats slot clear) and the slot write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt   <= '0;
      gate_q     <= '0;
      on_pend    <= '0;
      off_pend   <= '0;
      sweep_done <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) begin
        state[i]         <= IDLE;
        voice_volumes[i] <= '0;
      end
    end else begin
      tick_cnt   <= tick_cnt == TW'(PRESCALE - 1) ? '0 : tick_cnt + TW'(1);
      gate_q     <= gate;
      on_pend    <= (on_pend & ~clr) | (gate & ~gate_q);
      off_pend   <= (off_pend & ~clr) | (~gate & gate_q);
      sweep_done <= tick_cnt == TW'(N_VOICES - 1);
      if (slot) begin
        state[v]         <= nxt_state;
        voice_volumes[v] <= nxt_level;
      end
    end
  end
endmodule
